// File: rtl/rle_run_tokeniser_if.sv
// Pixel-in / token-out bundle for rle_run_tokeniser.
// Optional ones_count exists only with RLE_TOKENISER_ONES_COUNT_EN.
interface rle_run_tokeniser_if #(
  parameter int LEN_W = 11,
  parameter int OC_W  = 19
);
  logic             enable;
  logic             bit_in;
  logic             tok_ready;
  logic             tok_valid;
  logic             tok_value;
  logic [LEN_W-1:0] tok_length;
  logic             tok_eol;
  logic             tok_eof;
  logic             overflow;
  logic             frame_done;
`ifdef RLE_TOKENISER_ONES_COUNT_EN
  logic [OC_W-1:0]  ones_count;
`endif

  modport slave (
    input  enable, bit_in, tok_ready,
    output tok_valid, tok_value, tok_length,
    output tok_eol, tok_eof, overflow, frame_done
`ifdef RLE_TOKENISER_ONES_COUNT_EN
    , output ones_count
`endif
  );

  modport master (
    output enable, bit_in, tok_ready,
    input  tok_valid, tok_value, tok_length,
    input  tok_eol, tok_eof, overflow, frame_done
`ifdef RLE_TOKENISER_ONES_COUNT_EN
    , input ones_count
`endif
  );
endinterface

// File: rtl/rle_run_tokeniser.sv
// Mask-stream run tokeniser with 2-write show-ahead token FIFO.
// Define RLE_TOKENISER_ONES_COUNT_EN to add the per-frame ones_count.
module rle_run_tokeniser #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 16
) (
  input  logic CLK,
  input  logic rst_n,
  rle_run_tokeniser_if.slave bus
);
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = LEN_W + 3;
  localparam logic [LEN_W-1:0] RUN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [0:0]       r_state;
  logic             r_val;
  logic [LEN_W-1:0] r_len;
  logic [TW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_fd;

  logic             w_en;
  logic             w_px;
  logic             w_eol;
  logic             w_lastln;
  logic             w_first;
  logic             w_same;
  logic             w_max;
  logic [0:0]       w_state_n;
  logic             w_val_n;
  logic [LEN_W-1:0] w_len_n;
  logic             w_push0;
  logic             w_push1;
  logic [TW-1:0]    w_tok0;
  logic [TW-1:0]    w_tok1;
  logic [CW-1:0]    w_free;
  logic [CW-1:0]    w_req;
  logic [CW-1:0]    w_nwr;
  logic             w_drop;
  logic             w_pop;
  logic [AW-1:0]    w_wp1;
  logic [TW-1:0]    w_head;

  assign w_en     = bus.enable;
  assign w_px     = bus.bit_in;
  assign w_eol    = (r_x == XW'(IMG_WIDTH - 1));
  assign w_lastln = (r_y == YW'(IMG_HEIGHT - 1));
  assign w_first  = (r_x == '0) && (r_y == '0);
  assign w_same   = (w_px == r_val);
  assign w_max    = (r_len == RUN_MAX);

  // Run state machine: decide next run and up to two closing tokens
  always_comb begin
    w_state_n = r_state;
    w_val_n   = r_val;
    w_len_n   = r_len;
    w_push0   = 1'b0;
    w_push1   = 1'b0;
    w_tok0    = '0;
    w_tok1    = '0;
    if (w_en) begin
      if (r_state == S_IDLE) begin
        if (w_eol) begin
          w_push0 = 1'b1;
          w_tok0  = {w_px, LEN_ONE, 1'b1, w_lastln};
        end else begin
          w_state_n = S_RUN;
          w_val_n   = w_px;
          w_len_n   = LEN_ONE;
        end
      end else begin
        unique case (1'b1)
          w_same && !w_eol && !w_max: begin
            w_len_n = r_len + LEN_ONE;
          end
          w_same && w_eol && !w_max: begin
            w_push0   = 1'b1;
            w_tok0    = {r_val, r_len + LEN_ONE, 1'b1, w_lastln};
            w_state_n = S_IDLE;
          end
          w_same && w_eol && w_max: begin
            w_push0   = 1'b1;
            w_tok0    = {r_val, RUN_MAX, 2'b00};
            w_push1   = 1'b1;
            w_tok1    = {r_val, LEN_ONE, 1'b1, w_lastln};
            w_state_n = S_IDLE;
          end
          w_same && !w_eol && w_max: begin
            w_push0 = 1'b1;
            w_tok0  = {r_val, RUN_MAX, 2'b00};
            w_len_n = LEN_ONE;
          end
          !w_same && !w_eol: begin
            w_push0 = 1'b1;
            w_tok0  = {r_val, r_len, 2'b00};
            w_val_n = w_px;
            w_len_n = LEN_ONE;
          end
          default: begin
            w_push0   = 1'b1;
            w_tok0    = {r_val, r_len, 2'b00};
            w_push1   = 1'b1;
            w_tok1    = {w_px, LEN_ONE, 1'b1, w_lastln};
            w_state_n = S_IDLE;
          end
        endcase
      end
    end
  end

  assign w_free = CW'(FIFO_DEPTH) - r_cnt;
  assign w_req  = CW'(w_push0) + CW'(w_push1);
  assign w_drop = (w_req > w_free);
  assign w_nwr  = w_drop ? w_free : w_req;
  assign w_pop  = (r_cnt != '0) && bus.tok_ready;
  assign w_wp1  = r_wp + AW'(1);

  // Pixel position counters, advancing only on consumed pixels
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_en) begin
      if (w_eol) begin
        r_x <= '0;
        r_y <= w_lastln ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // Open-run registers
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_val   <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_n;
      r_val   <= w_val_n;
      r_len   <= w_len_n;
    end
  end

  // FIFO storage: first token at wp, second at wp+1 when room
  always_ff @(posedge CLK) begin
    if (rst_n) begin
      if (w_nwr != '0) r_mem[r_wp] <= w_tok0;
      if (w_nwr == CW'(2)) r_mem[w_wp1] <= w_tok1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_nwr);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + w_nwr - CW'(w_pop);
    end
  end

  // Sticky drop flag, rearmed by the first pixel of a frame
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_en && w_first) begin
      r_ovf <= w_drop;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end
  end

  // End-of-frame pulse after the last pixel is consumed
  always_ff @(posedge CLK) begin
    if (!rst_n) r_fd <= 1'b0;
    else        r_fd <= w_en && w_eol && w_lastln;
  end

  assign w_head         = (r_cnt != '0) ? r_mem[r_rp] : '0;
  assign bus.tok_valid  = (r_cnt != '0);
  assign bus.tok_value  = w_head[TW-1];
  assign bus.tok_length = w_head[TW-2:2];
  assign bus.tok_eol    = w_head[1];
  assign bus.tok_eof    = w_head[0];
  assign bus.overflow   = r_ovf;
  assign bus.frame_done = r_fd;

`ifdef RLE_TOKENISER_ONES_COUNT_EN
  localparam int OW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  logic [OW-1:0] r_acc;
  logic [OW-1:0] r_ones;

  // Count ones within a frame, publish total at frame end
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ones <= '0;
    end else if (w_en) begin
      if (w_eol && w_lastln) begin
        r_ones <= r_acc + OW'(w_px);
        r_acc  <= '0;
      end else begin
        r_acc <= r_acc + OW'(w_px);
      end
    end
  end

  assign bus.ones_count = r_ones;
`endif
endmodule

// File: doc/rle_run_tokeniser.md
Name: rle_run_tokeniser

Overview:
- Sits directly upstream of the run-length decode/display path. Consumes the 1-bit per-pixel mask stream, one pixel per enabled cycle in raster order.
- Emits buffered run tokens {value, length, end-of-line, end-of-frame} over a valid/ready interface.
- Runs never cross a line boundary. Two tokens can close in the same cycle; a 2-write FIFO absorbs them, so short streaks near edges and close transitions are never merged or lost silently.

Parameters:
- IMG_WIDTH, 640, pixels per line
- IMG_HEIGHT, 480, lines per frame
- LEN_W, 11, run-length field width; max run RUN_MAX = 2^LEN_W-1
- FIFO_DEPTH, 16, token FIFO entries (power of 2, >=4)

Ports:
- CLK  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  pixel valid; bit_in is consumed only when high
- bit_in  in  1  mask pixel
- tok_ready  in  1  downstream accepts head token
- tok_valid  out  1  FIFO non-empty
- tok_value  out  1  run pixel value
- tok_length  out  LEN_W  run length, 1..RUN_MAX
- tok_eol  out  1  run ends its line
- tok_eof  out  1  run ends its frame (implies tok_eol)
- overflow  out  1  sticky: at least one token dropped this frame
- frame_done  out  1  1-cycle pulse, registered, after the last pixel of a frame is consumed

Behaviour:
- Reset (rst_n=0 at a CLK edge): x=0, y=0, state=IDLE, FIFO emptied, overflow=0, frame_done=0. All tok_* outputs read 0. Any partial run is discarded. Reset takes priority over all other activity.
- Counters: x and y advance only on enable. x wraps at IMG_WIDTH-1 and y increments on that wrap. y wraps at IMG_HEIGHT-1 and frame_done pulses next cycle.
- State IDLE (no open run), enabled pixel p:
  - opens a run with value=p, len=1, and moves to RUN;
  - if p is the last pixel of the line, instead pushes {p,1,eol=1,eof=last line} and stays IDLE.
- State RUN, enabled pixel p with open run (v,len), evaluated in this order:
  - p==v, len<RUN_MAX, not end of line: len+1.
  - p==v, end of line: push {v,len+1,1,eof}; go to IDLE. If len+1 would exceed RUN_MAX, push {v,RUN_MAX,0,0} then {v,1,1,eof} instead.
  - p==v, len==RUN_MAX, not end of line: push {v,RUN_MAX,0,0}; open (v,1).
  - p!=v, not end of line: push {v,len,0,0}; open (p,1).
  - p!=v, end of line: push {v,len,0,0} then {p,1,1,eof}, both in the same cycle, in that order; go to IDLE.
- Nothing advances when enable=0.
- FIFO:
  - Up to 2 writes and 1 read per cycle.
  - Free space is computed before the same-cycle pop, so a full FIFO drops a push even while popping.
  - When two pushes meet only one free slot, the first is written and the second dropped.
  - Every drop sets overflow.
  - overflow clears on reset, or in the cycle the first pixel of a new frame (x=0, y=0) is consumed. A drop in that same cycle keeps it set.
- Read side:
  - Show-ahead FIFO: tok_* reflect the head entry combinationally from FIFO registers.
  - Pop occurs when tok_valid && tok_ready.
  - tok_valid deasserts the cycle after the last entry pops.
- Latency: a token is visible on tok_valid the cycle after the pixel that closes it, if the FIFO was empty.
- Order preserved; no token has length 0.

Optional Feature:
- Macro RLE_TOKENISER_ONES_COUNT_EN.
- When defined: adds output ones_count (width ceil(log2(IMG_WIDTH*IMG_HEIGHT+1))). It holds the number of 1-pixels consumed in the last complete frame and updates in the same cycle frame_done pulses. Reset value 0. It counts pixels consumed, independent of whether their tokens were dropped.
- When undefined: no port and no counter logic.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=2, LEN_W=3, FIFO_DEPTH=4, tok_ready=1 unless stated):
- Line 0 = 1,1,1,0,0,0,0,0 -> tokens {1,3,0,0}, {0,5,1,0}.
- Line 1 = 0,0,0,0,0,0,0,1 -> {0,7,0,0}, {1,1,1,1}, both pushed in one cycle; frame_done pulses once.
- Eight 1s on one line -> {1,7,0,0}, {1,1,1,eof} (RUN_MAX saturation combined with end of line).
- tok_ready=0 for a whole frame of alternating 1,0 (16 tokens) -> exactly 4 tokens held; first 4 in order; overflow=1. Next frame's first pixel clears overflow.
- rst_n=0 mid-line after 3 pixels, then line 1,0,1,0,1,0,1,0 -> no stale token; first token {1,1,0,0}; x,y restart at 0.
- enable toggled every other cycle with line 1×4,0×4 -> same tokens as gapless input: {1,4,0,0}, {0,4,1,0}.
